// File: rtl/dmi_nway_lockstep_pkg.sv
// Shared types for the N-copy DMI lockstep driver: op encodings, FSM states and
// the default-width request record.
package dmi_lockstep_pkg;

  localparam int DMI_OP_W   = 2;
  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;

  localparam logic [DMI_OP_W-1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [DMI_OP_W-1:0] DMI_OP_READ  = 2'd1;
  localparam logic [DMI_OP_W-1:0] DMI_OP_WRITE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_COLLECT,
    S_RESPOND
  } state_t;

  typedef struct packed {
    logic [DMI_OP_W-1:0]   op;
    logic [DMI_ADDR_W-1:0] addr;
    logic [DMI_DATA_W-1:0] data;
  } dmi_req_t;

endpackage

// File: rtl/dmi_nway_lockstep_if.sv
// Host-side DMI channel and N-copy broadcast channel. The lockstep driver is the
// slave of the host channel and the master of the copy channel.
interface dmi_host_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int OP_W   = 2
);
  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_mismatch;

  modport master (
    output req_valid, req_op, req_addr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_mismatch
  );
  modport slave (
    input  req_valid, req_op, req_addr, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_mismatch
  );
endinterface

interface dmi_copy_if #(
  parameter int NCOPIES = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 2
);
  logic [NCOPIES-1:0]        cp_req_valid;
  logic [NCOPIES-1:0]        cp_req_ready;
  logic [OP_W-1:0]           cp_req_op;
  logic [ADDR_W-1:0]         cp_req_addr;
  logic [DATA_W-1:0]         cp_req_data;
  logic [NCOPIES-1:0]        cp_resp_valid;
  logic [NCOPIES*DATA_W-1:0] cp_resp_data;

  modport master (
    output cp_req_valid, cp_req_op, cp_req_addr, cp_req_data,
    input  cp_req_ready, cp_resp_valid, cp_resp_data
  );
  modport slave (
    input  cp_req_valid, cp_req_op, cp_req_addr, cp_req_data,
    output cp_req_ready, cp_resp_valid, cp_resp_data
  );
endinterface

// File: rtl/dmi_nway_lockstep_fifo.sv
// Synchronous request FIFO with first-word fall-through head; one extra pointer
// bit distinguishes full from empty.
module dmi_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop frees the head slot in the same cycle, so a full FIFO may still take a push.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/dmi_nway_lockstep.sv
// N-copy DMI lockstep driver: buffers host requests, broadcasts each to NCOPIES
// copies, collects all responses and flags divergence. DMI_LOCKSTEP_VOTE_EN selects majority-vote response data.
module dmi_nway_lockstep
  import dmi_lockstep_pkg::*;
#(
  parameter int NCOPIES    = 4,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int OP_W       = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TMO_W      = 8
) (
  input  logic               clock,
  input  logic               reset,
  dmi_host_if.slave          host,
  dmi_copy_if.master         cp,
  output logic               diverged,
  output logic [NCOPIES-1:0] diverged_mask
);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  state_t             state_q, state_d;
  req_t               fifo_wdata, fifo_rdata, cur_q;
  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [NCOPIES-1:0] acc_q, acc_d, got_q, got_d;
  logic [DATA_W-1:0]  cap_q [NCOPIES];
  logic [DATA_W-1:0]  cap_d [NCOPIES];
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               enter_respond;
  logic [NCOPIES-1:0] issue_valid, bad;
  logic               resp_mis_d, resp_mis_q, diverged_q;
  logic [DATA_W-1:0]  resp_val, resp_data_q;
  logic [NCOPIES-1:0] mask_q;

  assign fifo_push  = host.req_valid && !fifo_full;
  assign fifo_wdata = '{op: host.req_op, addr: host.req_addr, data: host.req_data};

  dmi_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(req_t))
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign issue_valid = (state_q == S_ISSUE) ? ~acc_q : '0;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    got_d         = got_q;
    cap_d         = cap_q;
    tmo_d         = tmo_q;
    fifo_pop      = 1'b0;
    enter_respond = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          acc_d    = '0;
          got_d    = '0;
          tmo_d    = '0;
          for (int i = 0; i < NCOPIES; i++) cap_d[i] = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE, S_COLLECT: begin
        // A copy may answer in the very cycle its request is accepted.
        for (int i = 0; i < NCOPIES; i++) begin
          if (cp.cp_resp_valid[i] && !got_q[i]) begin
            got_d[i] = 1'b1;
            cap_d[i] = cp.cp_resp_data[i*DATA_W +: DATA_W];
          end
        end
        acc_d = acc_q | (issue_valid & cp.cp_req_ready);
        tmo_d = tmo_q + 1'b1;
        if (state_q == S_COLLECT && &got_d) begin
          state_d       = S_RESPOND;
          enter_respond = 1'b1;
        end else if (tmo_q == TMO_MAX) begin
          state_d       = S_RESPOND;
          enter_respond = 1'b1;
        end else if (state_q == S_ISSUE && &acc_d) begin
          state_d = S_COLLECT;
        end
      end
      S_RESPOND: begin
        if (host.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Missing copies (never accepted or never answered) count as divergent; copy 0 is the reference.
  always_comb begin
    bad = '0;
    for (int i = 0; i < NCOPIES; i++)
      bad[i] = !(acc_d[i] && got_d[i]) || (got_d[i] && got_d[0] && (cap_d[i] != cap_d[0]));
    resp_mis_d = |bad;
  end

`ifdef DMI_LOCKSTEP_VOTE_EN
  function automatic logic [DATA_W-1:0] majority(input logic [DATA_W-1:0] d [NCOPIES],
                                                 input logic [NCOPIES-1:0] en);
    int ones;
    int voters;
    majority = d[0];
    for (int b = 0; b < DATA_W; b++) begin
      ones   = 0;
      voters = 0;
      for (int i = 0; i < NCOPIES; i++) begin
        if (en[i]) begin
          voters++;
          if (d[i][b]) ones++;
        end
      end
      // Ties keep copy 0's bit, already loaded above.
      if (2 * ones > voters)      majority[b] = 1'b1;
      else if (2 * ones < voters) majority[b] = 1'b0;
    end
  endfunction

  assign resp_val = majority(cap_d, got_d);
`else
  assign resp_val = cap_d[0];
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      acc_q       <= '0;
      got_q       <= '0;
      tmo_q       <= '0;
      for (int i = 0; i < NCOPIES; i++) cap_q[i] <= '0;
      resp_data_q <= '0;
      resp_mis_q  <= 1'b0;
      diverged_q  <= 1'b0;
      mask_q      <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      got_q   <= got_d;
      tmo_q   <= tmo_d;
      cap_q   <= cap_d;
      if (fifo_pop) cur_q <= fifo_rdata;
      if (enter_respond) begin
        resp_data_q <= resp_val;
        resp_mis_q  <= resp_mis_d;
        diverged_q  <= diverged_q | resp_mis_d;
        mask_q      <= mask_q | bad;
      end
    end
  end

  assign host.req_ready     = !fifo_full;
  assign host.resp_valid    = (state_q == S_RESPOND);
  assign host.resp_data     = resp_data_q;
  assign host.resp_mismatch = resp_mis_q;
  assign cp.cp_req_valid    = issue_valid;
  assign cp.cp_req_op       = cur_q.op;
  assign cp.cp_req_addr     = cur_q.addr;
  assign cp.cp_req_data     = cur_q.data;
  assign diverged           = diverged_q;
  assign diverged_mask      = mask_q;

endmodule

// File: tb/tb_dmi_nway_lockstep.sv
// Directed bench for dmi_nway_lockstep with four modelled copies that answer one
// cycle after acceptance; expected values are hand-computed per scenario.
module tb_dmi_nway_lockstep;
  import dmi_lockstep_pkg::*;

  localparam int NC = 4;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int OW = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dmi_host_if #(.ADDR_W(AW), .DATA_W(DW), .OP_W(OW)) host ();
  dmi_copy_if #(.NCOPIES(NC), .ADDR_W(AW), .DATA_W(DW), .OP_W(OW)) cp ();
  logic          diverged;
  logic [NC-1:0] diverged_mask;

  dmi_nway_lockstep #(
    .NCOPIES(NC), .ADDR_W(AW), .DATA_W(DW), .OP_W(OW), .FIFO_DEPTH(4), .TMO_W(8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .host          (host),
    .cp            (cp),
    .diverged      (diverged),
    .diverged_mask (diverged_mask)
  );

  int checks = 0;
  int errors = 0;

  // Copy model controls
  logic [NC-1:0] silent;
  logic          use_addr;
  logic [DW-1:0] resp_val [NC];
  logic [NC-1:0] fire_q;
  logic [AW-1:0] addr_q [NC];

  // Each copy answers one cycle after its request is accepted; samples 1 time unit past the negedge.
  initial begin
    cp.cp_resp_valid = '0;
    cp.cp_resp_data  = '0;
    fire_q           = '0;
    for (int i = 0; i < NC; i++) addr_q[i] = '0;
    forever begin
      @(negedge clock);
      #1;
      for (int i = 0; i < NC; i++) begin
        cp.cp_resp_valid[i] = fire_q[i] & ~silent[i];
        cp.cp_resp_data[i*DW +: DW] = use_addr ? (32'h5A00_0000 | 32'(addr_q[i])) : resp_val[i];
        fire_q[i] = cp.cp_req_valid[i] & cp.cp_req_ready[i];
        if (fire_q[i]) addr_q[i] = cp.cp_req_addr;
      end
    end
  end

  task automatic push(input dmi_req_t r);
    @(negedge clock);
    host.req_valid = 1'b1;
    host.req_op    = r.op;
    host.req_addr  = r.addr;
    host.req_data  = r.data;
    @(negedge clock);
    host.req_valid = 1'b0;
  endtask

  // k = 1 is the current negedge; returns the index at which resp_valid was seen (or budget).
  task automatic wait_resp(input int budget, output int k);
    k = 1;
    while (host.resp_valid !== 1'b1 && k < budget) begin
      @(negedge clock);
      k++;
    end
  endtask

  task automatic accept_resp();
    host.resp_ready = 1'b1;
    @(negedge clock);
    host.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++; if (host.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", host.req_ready); end
    checks++; if (host.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", host.resp_valid); end
    checks++; if (cp.cp_req_valid !== 4'b0000) begin errors++; $display("FAIL rst_cp_req_valid got %b exp 0000", cp.cp_req_valid); end
    checks++; if (host.resp_data !== 32'h0) begin errors++; $display("FAIL rst_resp_data got %h exp 0", host.resp_data); end
    checks++; if ({diverged, diverged_mask} !== 5'b0) begin errors++; $display("FAIL rst_diverged got %b/%b exp 0/0000", diverged, diverged_mask); end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int k;
    push('{op: DMI_OP_READ, addr: 7'h10, data: 32'h0});
    wait_resp(20, k);
    checks++; if (k !== 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", k); end
    checks++; if (host.resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_data got %h exp deadbeef", host.resp_data); end
    checks++; if (host.resp_mismatch !== 1'b0) begin errors++; $display("FAIL basic_mismatch got %b exp 0", host.resp_mismatch); end
    checks++; if (diverged !== 1'b0) begin errors++; $display("FAIL basic_diverged got %b exp 0", diverged); end
    accept_resp();
    checks++; if (host.resp_valid !== 1'b0) begin errors++; $display("FAIL basic_resp_drop got %b exp 0", host.resp_valid); end
  endtask

  task automatic test_stall();
    int k;
    cp.cp_req_ready = 4'b1011;
    push('{op: DMI_OP_WRITE, addr: 7'h22, data: 32'h0BAD_F00D});
    @(negedge clock);
    checks++; if (cp.cp_req_valid !== 4'b1111) begin errors++; $display("FAIL stall_issue got %b exp 1111", cp.cp_req_valid); end
    for (int s = 0; s < 4; s++) begin
      @(negedge clock);
      checks++; if (cp.cp_req_valid !== 4'b0100) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 0100", s, cp.cp_req_valid); end
      checks++;
      if ({cp.cp_req_op, cp.cp_req_addr, cp.cp_req_data} !== {DMI_OP_WRITE, 7'h22, 32'h0BAD_F00D}) begin
        errors++; $display("FAIL stall_fields[%0d] got %h/%h/%h exp 2/22/0badf00d", s, cp.cp_req_op, cp.cp_req_addr, cp.cp_req_data);
      end
    end
    cp.cp_req_ready = 4'b1111;
    wait_resp(20, k);
    checks++; if (k !== 3) begin errors++; $display("FAIL stall_latency got %0d exp 3", k); end
    checks++; if (host.resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_data got %h exp deadbeef", host.resp_data); end
    checks++; if ({host.resp_mismatch, diverged_mask} !== 5'b0) begin errors++; $display("FAIL stall_mismatch got %b/%b exp 0/0000", host.resp_mismatch, diverged_mask); end
    accept_resp();
  endtask

  task automatic test_back_to_back();
    int k;
    logic [AW-1:0] addrs [5];
    addrs[0] = 7'h11; addrs[1] = 7'h22; addrs[2] = 7'h33; addrs[3] = 7'h44; addrs[4] = 7'h55;
    use_addr = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clock);
      checks++; if (host.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", j, host.req_ready); end
      host.req_valid = 1'b1;
      host.req_op    = DMI_OP_READ;
      host.req_addr  = addrs[j];
      host.req_data  = 32'h0;
    end
    @(negedge clock);
    host.req_valid = 1'b0;
    checks++; if (host.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got %b exp 0", host.req_ready); end
    for (int j = 0; j < 5; j++) begin
      wait_resp(20, k);
      checks++; if (host.resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_timeout[%0d] got %b exp 1", j, host.resp_valid); end
      checks++;
      if (host.resp_data !== (32'h5A00_0000 | 32'(addrs[j]))) begin
        errors++; $display("FAIL b2b_order[%0d] got %h exp %h", j, host.resp_data, 32'h5A00_0000 | 32'(addrs[j]));
      end
      accept_resp();
    end
    checks++; if (host.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_drained got %b exp 1", host.req_ready); end
    use_addr = 1'b0;
  endtask

  task automatic test_mismatch();
    int k;
    resp_val[3] = 32'hDEADBEEE;
    push('{op: DMI_OP_READ, addr: 7'h30, data: 32'h0});
    wait_resp(20, k);
    checks++; if (k !== 4) begin errors++; $display("FAIL mis_latency got %0d exp 4", k); end
    checks++; if (host.resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_data got %h exp deadbeef", host.resp_data); end
    checks++; if (host.resp_mismatch !== 1'b1) begin errors++; $display("FAIL mis_flag got %b exp 1", host.resp_mismatch); end
    checks++; if ({diverged, diverged_mask} !== 5'b1_1000) begin errors++; $display("FAIL mis_diverged got %b/%b exp 1/1000", diverged, diverged_mask); end
    accept_resp();
    resp_val[3] = 32'hDEADBEEF;
  endtask

  task automatic test_timeout();
    int k;
    silent[1] = 1'b1;
    push('{op: DMI_OP_READ, addr: 7'h31, data: 32'h0});
    wait_resp(400, k);
    // ISSUE entered at the edge after the push edge with count 0; leaves when count 255 is seen.
    checks++; if (k !== 258) begin errors++; $display("FAIL tmo_latency got %0d exp 258", k); end
    checks++; if (host.resp_mismatch !== 1'b1) begin errors++; $display("FAIL tmo_flag got %b exp 1", host.resp_mismatch); end
    checks++; if (host.resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL tmo_data got %h exp deadbeef", host.resp_data); end
    checks++; if ({diverged, diverged_mask} !== 5'b1_1010) begin errors++; $display("FAIL tmo_mask got %b/%b exp 1/1010", diverged, diverged_mask); end
    accept_resp();
    silent[1] = 1'b0;
  endtask

  task automatic test_vote();
    int k;
    logic [DW-1:0] exp_data;
`ifdef DMI_LOCKSTEP_VOTE_EN
    exp_data = 32'hCAFEF00D;
`else
    exp_data = 32'h12345678;
`endif
    resp_val[0] = 32'h12345678;
    for (int i = 1; i < NC; i++) resp_val[i] = 32'hCAFEF00D;
    push('{op: DMI_OP_NOP, addr: 7'h00, data: 32'h0});
    wait_resp(20, k);
    checks++; if (host.resp_data !== exp_data) begin errors++; $display("FAIL vote_data got %h exp %h", host.resp_data, exp_data); end
    checks++; if (host.resp_mismatch !== 1'b1) begin errors++; $display("FAIL vote_flag got %b exp 1", host.resp_mismatch); end
    checks++; if (diverged_mask !== 4'b1110) begin errors++; $display("FAIL vote_mask got %b exp 1110", diverged_mask); end
    accept_resp();
    for (int i = 0; i < NC; i++) resp_val[i] = 32'hDEADBEEF;
  endtask

  task automatic test_reset_mid();
    int k;
    silent[1] = 1'b1;
    push('{op: DMI_OP_READ, addr: 7'h40, data: 32'h0});
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if ({host.resp_valid, host.req_ready} !== 2'b01) begin errors++; $display("FAIL rmid_handshake got %b exp 01", {host.resp_valid, host.req_ready}); end
    checks++; if ({cp.cp_req_valid, cp.cp_req_addr} !== 11'h0) begin errors++; $display("FAIL rmid_copy got %b/%h exp 0000/00", cp.cp_req_valid, cp.cp_req_addr); end
    checks++; if ({diverged, diverged_mask} !== 5'b0) begin errors++; $display("FAIL rmid_sticky got %b/%b exp 0/0000", diverged, diverged_mask); end
    @(negedge clock);
    reset = 1'b1;
    silent[1] = 1'b0;
    push('{op: DMI_OP_READ, addr: 7'h41, data: 32'h0});
    wait_resp(20, k);
    checks++; if (k !== 4) begin errors++; $display("FAIL rmid_latency got %0d exp 4", k); end
    checks++; if (host.resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rmid_data got %h exp deadbeef", host.resp_data); end
    checks++; if ({host.resp_mismatch, diverged} !== 2'b00) begin errors++; $display("FAIL rmid_clean got %b/%b exp 0/0", host.resp_mismatch, diverged); end
    accept_resp();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    host.req_valid  = 1'b0;
    host.req_op     = '0;
    host.req_addr   = '0;
    host.req_data   = '0;
    host.resp_ready = 1'b0;
    cp.cp_req_ready = 4'b1111;
    silent          = '0;
    use_addr        = 1'b0;
    for (int i = 0; i < NC; i++) resp_val[i] = 32'hDEADBEEF;

    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_mismatch();
    test_timeout();
    test_vote();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
